// File: rtl/multi_impl_checker_pkg.sv
// Shared definitions for the multi-channel implication checker.
package multi_impl_checker_pkg;

    localparam int unsigned NCH_MAX = 32;
    localparam int unsigned HI_MAX  = 15;
    // Enough bits to count every age slot 0..HI_MAX in one cycle.
    localparam int unsigned HITS_W  = $clog2(HI_MAX + 2);
    localparam int unsigned POP_W   = HI_MAX + 1;

    typedef logic [HITS_W-1:0] hits_t;

    // Legal parameter envelope of the checker.
    function automatic bit params_ok(input int unsigned nch, input int unsigned lo,
                                     input int unsigned hi, input int unsigned cnt_w);
        return (nch >= 1) && (nch <= NCH_MAX) && (lo <= hi) && (hi <= HI_MAX) && (cnt_w >= 1);
    endfunction

    // Number of set bits across all age slots.
    function automatic hits_t popcount(input logic [POP_W-1:0] v);
        hits_t n;
        n = '0;
        for (int i = 0; i < int'(POP_W); i++) begin
            n = n + hits_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_impl_checker_chan.sv
// One checker channel: pending-attempt shift vector, hit/expire logic, counters.
module multi_impl_checker_chan
    import multi_impl_checker_pkg::*;
#(
    parameter int unsigned LO    = 1,
    parameter int unsigned HI    = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ant,
    input  logic             cons,
    input  logic             clr,
    output logic             pass,
    output logic             fail,
    output logic             fail_c,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned AW    = HI + 1;
    localparam int unsigned SUM_W = ((CNT_W > HITS_W) ? CNT_W : HITS_W) + 1;
    // Age slots that are inside the consequent window (age >= LO).
    localparam logic [AW-1:0]    WIN     = ~AW'((1 << LO) - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic             new_att;
    logic [AW-1:0]    ages;
    logic [AW-1:0]    ages_v;
    logic [AW-1:0]    hits;
    logic             pass_c;
    hits_t            npass;
    logic [SUM_W-1:0] pass_sum;
    logic [SUM_W-1:0] fail_sum;

    assign new_att = en & ant;
    // A disabled channel sees no attempts at all, so nothing can pass or fail.
    assign ages_v  = ages & {AW{en}};
    assign hits    = ages_v & WIN & {AW{cons}};
    assign pass_c  = |hits;
    assign fail_c  = ages_v[HI] & ~hits[HI];
    assign npass   = popcount(POP_W'(hits));

    if (HI > 0) begin : g_pend
        logic [HI:1] pend;

        // Age every surviving attempt by one; discharged and expired ones drop out.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend <= '0;
            end else begin
                pend <= ages_v[HI-1:0] & ~hits[HI-1:0];
            end
        end

        assign ages = {pend, new_att};
    end else begin : g_nopend
        assign ages = new_att;
    end

    // Saturating sums for both counters.
    always_comb begin
        pass_sum = SUM_W'(pass_cnt) + SUM_W'(npass);
        fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_c);
    end

    // Registered pulses and counters; clr wipes counters but never the pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass     <= 1'b0;
            fail     <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass <= pass_c;
            fail <= fail_c;
            if (clr) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
            end else begin
                pass_cnt <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
                fail_cnt <= (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/multi_impl_checker.sv
// Multi-channel `ant |-> ##[LO:HI] cons` checker with sticky error and first-fail capture.
module multi_impl_checker
    import multi_impl_checker_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned LO    = 1,
    parameter int unsigned HI    = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         ant,
    input  logic [NCH-1:0]         cons,
    input  logic                   clr,
    output logic [NCH-1:0]         pass,
    output logic [NCH-1:0]         fail,
    output logic [NCH*CNT_W-1:0]   pass_cnt,
    output logic [NCH*CNT_W-1:0]   fail_cnt,
    output logic                   err_sticky,
    output logic                   first_fail_vld,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_fail_ch
);

    localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam bit          PARAMS_OK = params_ok(NCH, LO, HI, CNT_W);

    if (!PARAMS_OK) begin : g_bad_params
        $error("multi_impl_checker: illegal parameters NCH=%0d LO=%0d HI=%0d CNT_W=%0d",
               NCH, LO, HI, CNT_W);
    end

    logic [NCH-1:0]  fail_c;
    logic [CH_W-1:0] ff_idx;

    for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
        multi_impl_checker_chan #(
            .LO    (LO),
            .HI    (HI),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .ant      (ant[i]),
            .cons     (cons[i]),
            .clr      (clr),
            .pass     (pass[i]),
            .fail     (fail[i]),
            .fail_c   (fail_c[i]),
            .pass_cnt (pass_cnt[i*CNT_W +: CNT_W]),
            .fail_cnt (fail_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Lowest-index failing channel this cycle.
    always_comb begin
        ff_idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (fail_c[i]) begin
                ff_idx = CH_W'(i);
            end
        end
    end

    // Sticky error and first-fail capture; a fail coinciding with clr is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky     <= 1'b0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
        end else if (clr) begin
            err_sticky     <= 1'b0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
        end else begin
            if (|fail_c) begin
                err_sticky <= 1'b1;
            end
            if (!first_fail_vld && (|fail_c)) begin
                first_fail_vld <= 1'b1;
                first_fail_ch  <= ff_idx;
            end
        end
    end

endmodule

// File: tb/tb_multi_impl_checker.sv
// Scoreboard bench: attempt-list reference model feeds expectations, a monitor compares each cycle.
module tb_multi_impl_checker;

    localparam int unsigned NCH   = 4;
    localparam int unsigned LO    = 1;
    localparam int unsigned HI    = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CH_W  = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0]       en = '0;
    logic [NCH-1:0]       ant = '0;
    logic [NCH-1:0]       cons = '0;
    logic                 clr = 1'b0;
    logic [NCH-1:0]       pass;
    logic [NCH-1:0]       fail;
    logic [NCH*CNT_W-1:0] pass_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;
    logic                 err_sticky;
    logic                 first_fail_vld;
    logic [CH_W-1:0]      first_fail_ch;

    multi_impl_checker #(
        .NCH   (NCH),
        .LO    (LO),
        .HI    (HI),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .ant            (ant),
        .cons           (cons),
        .clr            (clr),
        .pass           (pass),
        .fail           (fail),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .err_sticky     (err_sticky),
        .first_fail_vld (first_fail_vld),
        .first_fail_ch  (first_fail_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0]       pass;
        logic [NCH-1:0]       fail;
        logic [NCH*CNT_W-1:0] pcnt;
        logic [NCH*CNT_W-1:0] fcnt;
        logic                 err;
        logic                 ffv;
        logic [CH_W-1:0]      ffc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    // Reference model: each channel keeps a list of outstanding attempt ages.
    int m_ages[NCH][$];
    int m_pc[NCH];
    int m_fc[NCH];
    bit m_err;
    bit m_ffv;
    int m_ffc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and push the response the model predicts for it.
    task automatic step(input logic [NCH-1:0] e, input logic [NCH-1:0] a,
                        input logic [NCH-1:0] c, input logic cl, input logic r);
        exp_t ex;
        int   np;
        int   nf;
        int   surv[$];
        bit   any_fail;
        int   low_fail;
        @(negedge clk);
        en = e; ant = a; cons = c; clr = cl; rst = r;
        ex.pass = '0;
        ex.fail = '0;
        any_fail = 1'b0;
        low_fail = 0;
        for (int i = 0; i < int'(NCH); i++) begin
            np = 0;
            nf = 0;
            if (r || !e[i]) begin
                m_ages[i].delete();
            end else begin
                if (a[i]) m_ages[i].push_back(0);
                surv.delete();
                for (int j = 0; j < m_ages[i].size(); j++) begin
                    if (c[i] && m_ages[i][j] >= int'(LO)) np++;
                    else if (m_ages[i][j] == int'(HI)) nf++;
                    else surv.push_back(m_ages[i][j] + 1);
                end
                m_ages[i] = surv;
            end
            ex.pass[i] = (np > 0);
            ex.fail[i] = (nf > 0);
            if (nf > 0 && !any_fail) begin
                any_fail = 1'b1;
                low_fail = i;
            end
            if (r || cl) begin
                m_pc[i] = 0;
                m_fc[i] = 0;
            end else begin
                m_pc[i] = (m_pc[i] + np > CMAX) ? CMAX : m_pc[i] + np;
                m_fc[i] = (m_fc[i] + nf > CMAX) ? CMAX : m_fc[i] + nf;
            end
            ex.pcnt[i*CNT_W +: CNT_W] = CNT_W'(m_pc[i]);
            ex.fcnt[i*CNT_W +: CNT_W] = CNT_W'(m_fc[i]);
        end
        if (r || cl) begin
            m_err = 1'b0;
            m_ffv = 1'b0;
            m_ffc = 0;
        end else if (any_fail) begin
            m_err = 1'b1;
            if (!m_ffv) begin
                m_ffv = 1'b1;
                m_ffc = low_fail;
            end
        end
        ex.err = m_err;
        ex.ffv = m_ffv;
        ex.ffc = CH_W'(m_ffc);
        sb.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('1, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compare the DUT response just after each edge against the oldest expectation.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                chk("pass",           64'(pass),           64'(ex.pass));
                chk("fail",           64'(fail),           64'(ex.fail));
                chk("pass_cnt",       64'(pass_cnt),       64'(ex.pcnt));
                chk("fail_cnt",       64'(fail_cnt),       64'(ex.fcnt));
                chk("err_sticky",     64'(err_sticky),     64'(ex.err));
                chk("first_fail_vld", 64'(first_fail_vld), 64'(ex.ffv));
                chk("first_fail_ch",  64'(first_fail_ch),  64'(ex.ffc));
            end
        end
    end

    // Stimulus: directed corner cases, then randomized traffic.
    initial begin
        logic [NCH-1:0] re;
        logic [NCH-1:0] ra;
        logic [NCH-1:0] rc;
        for (int i = 0; i < int'(NCH); i++) begin
            m_pc[i] = 0;
            m_fc[i] = 0;
        end
        m_err = 1'b0; m_ffv = 1'b0; m_ffc = 0;

        repeat (3) step('1, '0, '0, 1'b0, 1'b1);
        idle(2);
        // single attempt discharged one cycle later
        step('1, 4'b0001, '0, 1'b0, 1'b0);
        step('1, '0, 4'b0001, 1'b0, 1'b0);
        idle(2);
        // three overlapping attempts discharged by one consequent
        repeat (3) step('1, 4'b0001, '0, 1'b0, 1'b0);
        step('1, '0, 4'b0001, 1'b0, 1'b0);
        idle(3);
        // same-cycle consequent is outside the window (LO=1), so this expires
        step('1, 4'b0001, 4'b0001, 1'b0, 1'b0);
        idle(4);
        step('1, '0, '0, 1'b1, 1'b0);
        // ch1 and ch3 fail together, later ch0 fails, then clear
        step('1, 4'b1010, '0, 1'b0, 1'b0);
        idle(4);
        step('1, 4'b0001, '0, 1'b0, 1'b0);
        idle(4);
        step('1, '0, '0, 1'b1, 1'b0);
        idle(1);
        // attempt on ch2 dropped by disable, even with cons high while disabled
        step('1, 4'b0100, '0, 1'b0, 1'b0);
        step(4'b1011, '0, 4'b0100, 1'b0, 1'b0);
        idle(5);
        // reset with attempts pending on every channel
        step('1, '1, '0, 1'b0, 1'b0);
        step('1, '0, '0, 1'b0, 1'b1);
        idle(5);
        // saturation: ch0 fails every cycle, ch1 passes every cycle
        repeat (25) step('1, 4'b0011, 4'b0010, 1'b0, 1'b0);
        idle(5);
        // fail in the same cycle as clr
        step('1, 4'b0100, '0, 1'b1, 1'b0);
        idle(2);
        step('1, '0, '0, 1'b1, 1'b0);
        idle(4);

        for (int n = 0; n < 600; n++) begin
            re = ($urandom_range(0, 14) == 0) ? NCH'($urandom) : '1;
            ra = NCH'($urandom) & NCH'($urandom);
            rc = NCH'($urandom) & NCH'($urandom);
            step(re, ra, rc, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
        end
        idle(5);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
